// File: rtl/game_pkg.sv
// Shared playfield geometry, ball direction encodings and level sequencing states
// for the brick field and its paddle controller.
package game_pkg;

    localparam int unsigned ROWS  = 12;
    localparam int unsigned COLS  = 16;
    localparam int unsigned CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        DIR_UP_RIGHT   = 2'b00,
        DIR_UP_LEFT    = 2'b01,
        DIR_DOWN_RIGHT = 2'b10,
        DIR_DOWN_LEFT  = 2'b11
    } ball_dir_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PLAY,
        ST_CLEARED,
        ST_OVER
    } field_state_t;

    // Flat occupancy-map bit index of a cell: row*16+col.
    function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return (8'(row) * 8'(COLS)) + 8'(col);
    endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// Paddle position register: button/tick stepping with edge clamps, reload to the
// start column, and the paddle's 16-bit occupancy mask for its row.
module paddle_ctrl
    import game_pkg::*;
#(
    parameter int unsigned PADDLE_W    = 4,
    parameter int unsigned PADDLE_INIT = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            enable,
    input  logic            visible,
    input  logic            tick,
    input  logic            btn_left,
    input  logic            btn_right,
    output logic [3:0]      paddle_col,
    output logic [COLS-1:0] row_mask
);

    localparam logic [3:0]      MAX_COL  = 4'(COLS - PADDLE_W);
    localparam logic [3:0]      INIT_COL = 4'(PADDLE_INIT);
    localparam logic [COLS-1:0] BASE     = COLS'((1 << PADDLE_W) - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            paddle_col <= INIT_COL;
        end else if (load) begin
            paddle_col <= INIT_COL;
        end else if (enable && tick) begin
            if (btn_left && !btn_right && (paddle_col < MAX_COL)) begin
                paddle_col <= paddle_col + 4'd1;
            end else if (btn_right && !btn_left && (paddle_col != 4'd0)) begin
                paddle_col <= paddle_col - 4'd1;
            end
        end
    end

    always_comb begin
        row_mask = '0;
        if (visible) begin
            row_mask = BASE << paddle_col;
        end
    end

endmodule

// File: rtl/brick_field.sv
// 12x16 playfield: brick bitmap with ball-strike erasure, paddle overlay, score and
// brick count, and the LOAD/PLAY/CLEARED/OVER level sequence.
module brick_field
    import game_pkg::*;
#(
    parameter int unsigned BRICK_TOP   = 1,
    parameter int unsigned BRICK_ROWS  = 4,
    parameter int unsigned PADDLE_ROW  = 10,
    parameter int unsigned PADDLE_W    = 4,
    parameter int unsigned PADDLE_INIT = 6,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               ball_step,
    input  logic [3:0]         ball_row,
    input  logic [3:0]         ball_col,
    input  logic [1:0]         ball_dir,
    input  logic               game_over,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               paddle_tick,
    output logic [CELLS-1:0]   field_map,
    output logic [3:0]         paddle_col,
    output logic [6:0]         brick_count,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear,
    output logic               playing
);

    localparam logic [3:0]         BAND_LO   = 4'(BRICK_TOP);
    localparam logic [3:0]         BAND_HI   = 4'(BRICK_TOP + BRICK_ROWS);
    localparam logic [3:0]         LAST_ROW  = 4'(ROWS - 1);
    localparam logic [3:0]         LAST_COL  = 4'(COLS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    field_state_t    state, state_next;
    logic [3:0]      row_cnt;
    logic [COLS-1:0] bricks [ROWS];
    logic [COLS-1:0] paddle_mask;

    logic load_we, load_done, restart, erase_en, in_band;
    logic going_up, going_plus, row_ok, v_ok, s_ok, d_ok;
    logic v_hit, s_hit, d_hit;
    logic [3:0]         v_row, s_col;
    logic [1:0]         hits;
    logic [SCORE_W:0]   score_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // game_over is checked before the empty-field test, and either one suppresses erasure.
    always_comb begin
        state_next  = state;
        load_we     = 1'b0;
        load_done   = 1'b0;
        restart     = 1'b0;
        erase_en    = 1'b0;
        playing     = 1'b0;
        level_clear = 1'b0;
        case (state)
            ST_LOAD: begin
                load_we = 1'b1;
                if (row_cnt == LAST_ROW) begin
                    load_done  = 1'b1;
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                playing = 1'b1;
                if (game_over) begin
                    state_next = ST_OVER;
                end else if (brick_count == '0) begin
                    state_next = ST_CLEARED;
                end else begin
                    erase_en = ball_step;
                end
            end
            ST_CLEARED, ST_OVER: begin
                level_clear = (state == ST_CLEARED);
                if (start) begin
                    restart    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Neighbour cells of the ball for its direction; out-of-range cells never hit.
    always_comb begin
        going_up   = 1'b0;
        going_plus = 1'b0;
        case (ball_dir_t'(ball_dir))
            DIR_UP_RIGHT:   begin going_up = 1'b1; going_plus = 1'b0; end
            DIR_UP_LEFT:    begin going_up = 1'b1; going_plus = 1'b1; end
            DIR_DOWN_RIGHT: begin going_up = 1'b0; going_plus = 1'b0; end
            DIR_DOWN_LEFT:  begin going_up = 1'b0; going_plus = 1'b1; end
        endcase
        row_ok    = (ball_row <= LAST_ROW);
        v_row     = going_up ? (ball_row - 4'd1) : (ball_row + 4'd1);
        s_col     = going_plus ? (ball_col + 4'd1) : (ball_col - 4'd1);
        v_ok      = row_ok && (going_up ? (ball_row != 4'd0) : (ball_row != LAST_ROW));
        s_ok      = row_ok && (going_plus ? (ball_col != LAST_COL) : (ball_col != 4'd0));
        d_ok      = v_ok && s_ok;
        v_hit     = v_ok && bricks[v_row][ball_col];
        s_hit     = s_ok && bricks[ball_row][s_col];
        d_hit     = d_ok && !v_hit && !s_hit && bricks[v_row][s_col];
        hits      = 2'(v_hit) + 2'(s_hit) + 2'(d_hit);
        score_sum = {1'b0, score} + (SCORE_W + 1)'(hits);
        in_band   = (row_cnt >= BAND_LO) && (row_cnt < BAND_HI);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                bricks[r] <= '0;
            end
            row_cnt     <= '0;
            brick_count <= '0;
            score       <= '0;
        end else begin
            if (restart) begin
                row_cnt     <= '0;
                brick_count <= '0;
            end
            if (load_we) begin
                bricks[row_cnt] <= in_band ? '1 : '0;
                if (in_band) begin
                    brick_count <= brick_count + 7'd16;
                end
                row_cnt <= load_done ? '0 : (row_cnt + 4'd1);
            end
            if (erase_en) begin
                if (v_hit) bricks[v_row][ball_col] <= 1'b0;
                if (s_hit) bricks[ball_row][s_col] <= 1'b0;
                if (d_hit) bricks[v_row][s_col]    <= 1'b0;
                brick_count <= brick_count - 7'(hits);
                score       <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
            end
        end
    end

    // Paddle is kept off the map while a level is loading, so a fresh load starts from an empty map.
    paddle_ctrl #(
        .PADDLE_W    (PADDLE_W),
        .PADDLE_INIT (PADDLE_INIT)
    ) u_paddle (
        .clock      (clock),
        .reset      (reset),
        .load       (load_done),
        .enable     (playing),
        .visible    (state != ST_LOAD),
        .tick       (paddle_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .paddle_col (paddle_col),
        .row_mask   (paddle_mask)
    );

    always_comb begin
        field_map = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            field_map[cell_index(4'(r), 4'd0) +: COLS] =
                bricks[r] | ((r == PADDLE_ROW) ? paddle_mask : '0);
        end
    end

endmodule
